// File: rtl/alk_qshift_pkg.sv
// Shared types and helpers for the ALK/DPM Q shift register and step-loop sequencer.
package alk_qshift_pkg;

  typedef enum logic [1:0] {
    Q_HOLD = 2'b00,
    Q_LOAD = 2'b01,
    Q_SHL  = 2'b10,
    Q_SHR  = 2'b11
  } q_op_e;

  typedef enum logic [2:0] {
    SIN_ZERO   = 3'd0,
    SIN_ALU_SL = 3'd1,
    SIN_ALU_SR = 3'd2,
    SIN_ROT    = 3'd3,
    SIN_WBMSB  = 3'd4,
    SIN_ONE    = 3'd5,
    SIN_C32    = 3'd6,
    SIN_PSLC   = 3'd7
  } sin_sel_e;

  typedef enum logic [1:0] {
    SZ_BYTE     = 2'b00,
    SZ_WORD     = 2'b01,
    SZ_LONG     = 2'b10,
    SZ_LONG_ALT = 2'b11
  } q_size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } seq_state_e;

  // Active field width in bits; a word never exceeds the register itself.
  function automatic int unsigned size_bits(q_size_e sz, int unsigned width);
    case (sz)
      SZ_BYTE: return 8;
      SZ_WORD: return (width < 16) ? width : 16;
      default: return width;
    endcase
  endfunction

endpackage

// File: rtl/alk_qshift_if.sv
// Datapath-side signal bundle for alk_qshift_seq: Q control, shift-in sources, loop control and status.
interface alk_qshift_if #(
  parameter int WIDTH = 32,
  parameter int CNTW  = 6
);
  logic [1:0]       q_op_h;
  logic [WIDTH-1:0] q_wd_h;
  logic [1:0]       q_size_h;
  logic [2:0]       sin_sel_h;
  logic             alu_sout_shl_h;
  logic             alu_sout_shr_h;
  logic             c32_in_h;
  logic             wb_msb_h;
  logic             pslc_h;
  logic             loop_start_h;
  logic [CNTW-1:0]  loop_cnt_h;
  logic             loop_mul_h;
  logic [WIDTH-1:0] q_h;
  logic             q_sout_shl_h;
  logic             q_sout_shr_h;
  logic             loopf_h;
  logic             loop_busy_h;
  logic             loop_done_h;

  modport master (
    output q_op_h, q_wd_h, q_size_h, sin_sel_h, alu_sout_shl_h, alu_sout_shr_h,
           c32_in_h, wb_msb_h, pslc_h, loop_start_h, loop_cnt_h, loop_mul_h,
    input  q_h, q_sout_shl_h, q_sout_shr_h, loopf_h, loop_busy_h, loop_done_h
  );

  modport slave (
    input  q_op_h, q_wd_h, q_size_h, sin_sel_h, alu_sout_shl_h, alu_sout_shr_h,
           c32_in_h, wb_msb_h, pslc_h, loop_start_h, loop_cnt_h, loop_mul_h,
    output q_h, q_sout_shl_h, q_sout_shr_h, loopf_h, loop_busy_h, loop_done_h
  );
endinterface

// File: rtl/alk_qsin_mux.sv
// Shift-in source selection for Q, with the running loop overriding both the source and the direction.
module alk_qsin_mux
  import alk_qshift_pkg::*;
(
  input  sin_sel_e sin_sel_i,
  input  q_op_e    q_op_i,
  input  logic     run_i,
  input  logic     mul_i,
  input  logic     alu_sout_shl_i,
  input  logic     alu_sout_shr_i,
  input  logic     c32_in_i,
  input  logic     wb_msb_i,
  input  logic     pslc_i,
  input  logic     q_sout_shl_i,
  input  logic     q_sout_shr_i,
  output logic     sin_o,
  output logic     shift_en_o,
  output logic     shift_left_o
);

  logic left;

  // NOTE: every output gets a default first, so no path through the block can infer a latch.
  always_comb begin
    sin_o      = 1'b0;
    shift_en_o = 1'b0;
    left       = 1'b0;
    if (run_i) begin
      // Multiply shifts right taking the ALU LSB; divide shifts left taking the carry.
      shift_en_o = 1'b1;
      left       = !mul_i;
      sin_o      = mul_i ? alu_sout_shr_i : c32_in_i;
    end else begin
      shift_en_o = (q_op_i == Q_SHL) || (q_op_i == Q_SHR);
      left       = (q_op_i == Q_SHL);
      case (sin_sel_i)
        SIN_ZERO:   sin_o = 1'b0;
        SIN_ALU_SL: sin_o = alu_sout_shl_i;
        SIN_ALU_SR: sin_o = alu_sout_shr_i;
        SIN_ROT:    sin_o = left ? q_sout_shl_i : q_sout_shr_i;
        SIN_WBMSB:  sin_o = wb_msb_i;
        SIN_ONE:    sin_o = 1'b1;
        SIN_C32:    sin_o = c32_in_i;
        SIN_PSLC:   sin_o = pslc_i;
        default:    sin_o = 1'b0;
      endcase
    end
  end

  assign shift_left_o = left;

endmodule

// File: rtl/alk_qshift_seq.sv
// Registered Q with size-aware shift/rotate and an N-step sequencer driving multiply/divide loops.
module alk_qshift_seq
  import alk_qshift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNTW  = 6
) (
  input logic          clk,
  input logic          rst_l,
  alk_qshift_if.slave  bus
);

  logic [WIDTH-1:0] q_q, q_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  seq_state_e       state_q, state_d;

  logic [WIDTH-1:0] field_mask, msb_mask, shl_v, shr_v;
  int unsigned      fbits;
  logic             run, sin, shift_en, shift_left, sout_shl, sout_shr;
  q_op_e            q_op;

  assign q_op = q_op_e'(bus.q_op_h);
  assign run  = (state_q == ST_RUN);

  // Field mask covers bits [size-1:0]; msb_mask isolates the top bit of that field.
  always_comb begin
    fbits      = size_bits(q_size_e'(bus.q_size_h), WIDTH);
    field_mask = '1;
    if (fbits < WIDTH) field_mask = (WIDTH'(1) << fbits) - WIDTH'(1);
    msb_mask   = field_mask & ~(field_mask >> 1);
  end

  assign sout_shl = |(q_q & msb_mask);
  assign sout_shr = q_q[0];

  alk_qsin_mux u_sin_mux (
    .sin_sel_i      (sin_sel_e'(bus.sin_sel_h)),
    .q_op_i         (q_op),
    .run_i          (run),
    .mul_i          (bus.loop_mul_h),
    .alu_sout_shl_i (bus.alu_sout_shl_h),
    .alu_sout_shr_i (bus.alu_sout_shr_h),
    .c32_in_i       (bus.c32_in_h),
    .wb_msb_i       (bus.wb_msb_h),
    .pslc_i         (bus.pslc_h),
    .q_sout_shl_i   (sout_shl),
    .q_sout_shr_i   (sout_shr),
    .sin_o          (sin),
    .shift_en_o     (shift_en),
    .shift_left_o   (shift_left)
  );

  always_comb begin
    shl_v = {q_q[WIDTH-2:0], sin};
    shr_v = ((q_q >> 1) & ~msb_mask) | (sin ? msb_mask : '0);
    q_d   = q_q;
    if (shift_en) begin
      // Bits above the active field are held; only the field moves.
      q_d = (q_q & ~field_mask) | ((shift_left ? shl_v : shr_v) & field_mask);
    end else if (!run && q_op == Q_LOAD) begin
      q_d = bus.q_wd_h;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.loop_start_h) begin
          if (bus.loop_cnt_h != '0) begin
            state_d = ST_RUN;
            cnt_d   = bus.loop_cnt_h;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_RUN: begin
        // The step taken while the count reads 1 is the final one.
        cnt_d = cnt_q - CNTW'(1);
        if (cnt_q == CNTW'(1)) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      q_q     <= '0;
      cnt_q   <= '0;
      state_q <= ST_IDLE;
    end else begin
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  assign bus.q_h          = q_q;
  assign bus.q_sout_shl_h = sout_shl;
  assign bus.q_sout_shr_h = sout_shr;
  assign bus.loopf_h      = (state_q == ST_RUN);
  assign bus.loop_busy_h  = (state_q != ST_IDLE);
  assign bus.loop_done_h  = (state_q == ST_DONE);

endmodule

// File: tb/tb_alk_qshift_seq.sv
// Scoreboard bench for alk_qshift_seq: stimulus queues hand-computed expectations, a monitor checks each cycle.
module tb_alk_qshift_seq;
  import alk_qshift_pkg::*;

  logic clk = 1'b0;
  logic rst_l;
  int   total = 0;
  int   bad   = 0;

  typedef struct {
    string       name;
    logic [31:0] q;
    logic [2:0]  fl;    // {loopf, busy, done}
    bit          tc;
    logic [1:0]  taps;  // {sout_shl, sout_shr}
  } exp_t;

  exp_t sb[$];

  alk_qshift_if #(.WIDTH(32), .CNTW(6)) bus ();

  alk_qshift_seq #(.WIDTH(32), .CNTW(6)) dut (
    .clk   (clk),
    .rst_l (rst_l),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input string name, input logic [31:0] q, input logic [2:0] fl,
                      input bit tc = 1'b0, input logic [1:0] taps = 2'b00);
    exp_t e;
    e.name = name; e.q = q; e.fl = fl; e.tc = tc; e.taps = taps;
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic setq(input q_op_e op, input sin_sel_e sel, input q_size_e sz);
    bus.q_op_h    = op;
    bus.sin_sel_h = sel;
    bus.q_size_h  = sz;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check({e.name, "_q"}, 64'(bus.q_h), 64'(e.q));
        check({e.name, "_flags"}, 64'({bus.loopf_h, bus.loop_busy_h, bus.loop_done_h}), 64'(e.fl));
        if (e.tc) check({e.name, "_taps"}, 64'({bus.q_sout_shl_h, bus.q_sout_shr_h}), 64'(e.taps));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_l = 1'b0;
    bus.q_op_h = 2'b00; bus.q_wd_h = '0; bus.q_size_h = 2'b10; bus.sin_sel_h = 3'd0;
    bus.alu_sout_shl_h = 1'b0; bus.alu_sout_shr_h = 1'b0; bus.c32_in_h = 1'b0;
    bus.wb_msb_h = 1'b0; bus.pslc_h = 1'b0;
    bus.loop_start_h = 1'b0; bus.loop_cnt_h = '0; bus.loop_mul_h = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_q", 64'(bus.q_h), 64'h0);
    check("reset_flags", 64'({bus.loopf_h, bus.loop_busy_h, bus.loop_done_h}), 64'h0);
    rst_l = 1'b1;

    // Load, start a multiply loop, then abort it with an asynchronous reset.
    setq(Q_LOAD, SIN_ZERO, SZ_LONG); bus.q_wd_h = 32'h1234_5678;
    tick("load", 32'h1234_5678, 3'b000);
    setq(Q_HOLD, SIN_ZERO, SZ_LONG);
    bus.loop_start_h = 1'b1; bus.loop_cnt_h = 6'd5; bus.loop_mul_h = 1'b1;
    tick("abort_start", 32'h1234_5678, 3'b110);
    bus.loop_start_h = 1'b0;
    tick("abort_step", 32'h091A_2B3C, 3'b110);
    #2 rst_l = 1'b0;
    #1;
    check("async_rst_q", 64'(bus.q_h), 64'h0);
    check("async_rst_flags", 64'({bus.loopf_h, bus.loop_busy_h, bus.loop_done_h}), 64'h0);
    @(negedge clk);
    rst_l = 1'b1;
    tick("post_rst", 32'h0, 3'b000);

    // Byte rotate left and word rotate right leave the upper bits alone.
    setq(Q_LOAD, SIN_ZERO, SZ_LONG); bus.q_wd_h = 32'h1234_56A5;
    tick("load_a5", 32'h1234_56A5, 3'b000);
    setq(Q_SHL, SIN_ROT, SZ_BYTE);
    tick("rot_byte_l", 32'h1234_564B, 3'b000, 1'b1, 2'b01);
    setq(Q_SHR, SIN_ROT, SZ_WORD);
    tick("rot_word_r", 32'h1234_AB25, 3'b000, 1'b1, 2'b11);

    // Long rotates in both directions.
    setq(Q_LOAD, SIN_ZERO, SZ_LONG); bus.q_wd_h = 32'h8000_0001;
    tick("load_8001", 32'h8000_0001, 3'b000, 1'b1, 2'b11);
    setq(Q_SHR, SIN_ROT, SZ_LONG);
    tick("rot_long_r", 32'hC000_0000, 3'b000);
    setq(Q_SHL, SIN_ROT, SZ_LONG);
    tick("rot_long_l", 32'h8000_0001, 3'b000);

    // Remaining shift-in sources.
    setq(Q_LOAD, SIN_ZERO, SZ_LONG); bus.q_wd_h = 32'h0;
    tick("load_0", 32'h0, 3'b000);
    setq(Q_SHL, SIN_ONE, SZ_LONG);
    tick("sin_one", 32'h0000_0001, 3'b000);
    setq(Q_SHR, SIN_WBMSB, SZ_LONG); bus.wb_msb_h = 1'b1;
    tick("sin_wbmsb", 32'h8000_0000, 3'b000);
    setq(Q_SHL, SIN_ALU_SL, SZ_LONG); bus.alu_sout_shl_h = 1'b1;
    tick("sin_alu_sl", 32'h0000_0001, 3'b000);
    setq(Q_SHR, SIN_PSLC, SZ_LONG); bus.pslc_h = 1'b1;
    tick("sin_pslc", 32'h8000_0000, 3'b000);
    setq(Q_SHR, SIN_ZERO, SZ_LONG);
    tick("sin_zero", 32'h4000_0000, 3'b000);
    setq(Q_SHL, SIN_C32, SZ_LONG); bus.c32_in_h = 1'b1;
    tick("sin_c32", 32'h8000_0001, 3'b000);
    setq(Q_SHR, SIN_ALU_SR, SZ_LONG); bus.alu_sout_shr_h = 1'b1;
    tick("sin_alu_sr", 32'hC000_0000, 3'b000);
    setq(Q_HOLD, SIN_ONE, SZ_LONG);
    tick("hold", 32'hC000_0000, 3'b000);

    // Multiply loop of 4 steps; a restart and a load during RUN are both ignored.
    setq(Q_LOAD, SIN_ZERO, SZ_LONG); bus.q_wd_h = 32'h0;
    tick("mul_load", 32'h0, 3'b000);
    setq(Q_HOLD, SIN_ZERO, SZ_LONG);
    bus.loop_start_h = 1'b1; bus.loop_cnt_h = 6'd4; bus.loop_mul_h = 1'b1; bus.alu_sout_shr_h = 1'b1;
    tick("mul_start", 32'h0, 3'b110);
    bus.q_op_h = Q_LOAD; bus.q_wd_h = 32'hFFFF_FFFF; bus.loop_cnt_h = 6'd9;
    tick("mul_s1", 32'h8000_0000, 3'b110);
    setq(Q_HOLD, SIN_ZERO, SZ_LONG); bus.loop_start_h = 1'b0;
    tick("mul_s2", 32'hC000_0000, 3'b110);
    tick("mul_s3", 32'hE000_0000, 3'b110);
    tick("mul_s4", 32'hF000_0000, 3'b011);
    tick("mul_idle", 32'hF000_0000, 3'b000);

    // Zero count goes straight to DONE without shifting.
    bus.loop_start_h = 1'b1; bus.loop_cnt_h = 6'd0;
    tick("zero_done", 32'hF000_0000, 3'b011);
    bus.loop_start_h = 1'b0;
    tick("zero_idle", 32'hF000_0000, 3'b000);

    // Divide loop of 3 steps with the load taken in the start cycle.
    setq(Q_LOAD, SIN_ZERO, SZ_LONG); bus.q_wd_h = 32'h0;
    bus.loop_start_h = 1'b1; bus.loop_cnt_h = 6'd3; bus.loop_mul_h = 1'b0; bus.c32_in_h = 1'b1;
    tick("div_start", 32'h0, 3'b110);
    setq(Q_HOLD, SIN_ZERO, SZ_LONG); bus.loop_start_h = 1'b0;
    tick("div_s1", 32'h0000_0001, 3'b110);
    tick("div_s2", 32'h0000_0003, 3'b110);
    tick("div_s3", 32'h0000_0007, 3'b011);
    tick("div_idle", 32'h0000_0007, 3'b000);

    @(negedge clk);
    check("sb_drain", 64'(sb.size()), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alk_qshift_seq.md
Name: alk_qshift_seq

Overview:
Parametrised Q register with an integrated shift-in source selector and a step-loop sequencer for iterative multiply and divide in the ALK/DPM datapath. It succeeds the fixed combinational Q shift-in routing with a registered Q of configurable width and an operand-size-aware rotate. It adds a loop counter that generates LOOPF and a done pulse, so microcode can issue one start and get N shift/step cycles.

Parameters:
WIDTH, 32, Q register width in bits; must be a multiple of 4 and at least 8.
CNTW, 6, loop counter width; maximum step count is 2**CNTW-1.

Ports:
clk  input  1  system clock, all state updates on its rising edge.
rst_l  input  1  asynchronous active-low reset.
q_op_h  input  2  Q operation: 00 hold, 01 load, 10 shift left, 11 shift right.
q_wd_h  input  WIDTH  parallel load data (WBUS).
q_size_h  input  2  operand size: 00 byte (8), 01 word (16), 10/11 full WIDTH.
sin_sel_h  input  3  shift-in source code; see Behaviour.
alu_sout_shl_h  input  1  ALU shifter MSB out.
alu_sout_shr_h  input  1  ALU shifter LSB out.
c32_in_h  input  1  ALU carry out of MSB.
wb_msb_h  input  1  WBUS[WIDTH-1].
pslc_h  input  1  PSL.C.
loop_start_h  input  1  start an N-step loop.
loop_cnt_h  input  CNTW  number of steps N.
loop_mul_h  input  1  1 = multiply loop, 0 = divide loop.
q_h  output  WIDTH  Q register contents.
q_sout_shl_h  output  1  Q[size-1], the MSB of the active field.
q_sout_shr_h  output  1  Q[0].
loopf_h  output  1  loop flag, high while steps remain.
loop_busy_h  output  1  sequencer not idle.
loop_done_h  output  1  one-cycle pulse after the final step.

Behaviour:
- Reset is asynchronous and active-low on rst_l. All state is clocked on clk. On reset, q_h is 0, the counter is 0, the state is IDLE, and loopf_h, loop_busy_h and loop_done_h are 0.
- sin_sel_h codes:
  - 0: zero.
  - 1: ALU_SL, gives alu_sout_shl_h.
  - 2: ALU_SR, gives alu_sout_shr_h.
  - 3: ROT. On a left shift it gives q_sout_shl_h; on a right shift it gives q_sout_shr_h.
  - 4: WBMSB, gives wb_msb_h.
  - 5: ONE, gives 1.
  - 6: C32, gives c32_in_h.
  - 7: PSLC, gives pslc_h.
- Loop override: while state is RUN, the shift-in bit is set by the loop, not by sin_sel_h.
  - Multiply loop: alu_sout_shr_h, and the loop forces a right shift.
  - Divide loop: c32_in_h, and the loop forces a left shift.
  - q_op_h is ignored during RUN.
- Shift operations act on field bits [size-1:0] only. Bits above the field are held.
  - Shift left: field becomes {field[size-2:0], sin}.
  - Shift right: field becomes {sin, field[size-1:1]}.
- Load writes all WIDTH bits regardless of q_size_h.
- q_sout_shl_h and q_sout_shr_h are combinational from the current Q and q_size_h (zero-latency taps).
- Sequencer has three states.
  - IDLE → RUN: on loop_start_h with loop_cnt_h ≠ 0. The counter loads N.
  - IDLE → DONE: on loop_start_h with loop_cnt_h = 0. No shift is performed.
  - RUN: each cycle performs one shift step and decrements the counter. When the counter reaches 1, that cycle's step is the last one and the next state is DONE.
  - DONE → IDLE: unconditionally after one cycle.
- Loop outputs:
  - loop_done_h = (state == DONE).
  - loopf_h = (state == RUN).
  - loop_busy_h = (state != IDLE).
- loop_start_h while busy is ignored.
- A load in the same cycle as loop_start_h from IDLE is taken. The first step happens on the following cycle.
- Reset asserted mid-loop aborts to IDLE with Q cleared. No done pulse is produced.

Decomposition:
- Package alk_qshift_pkg holds:
  - q_op enum: HOLD, LOAD, SHL, SHR.
  - sin_sel enum: the 8 codes above.
  - q_size enum.
  - sequencer state enum.
  - Function size_bits(q_size, WIDTH).
- One sub-module, alk_qsin_mux: purely combinational source selection plus loop override, producing sin and the effective direction.

Test Plan:
- Reset: load Q = 0x12345678, then pulse rst_l low mid-cycle → q_h = 0 immediately, all flags 0.
- Rotate, byte size: Q = 0x000000A5, size = byte, sel = ROT, shift left ×1 → Q = 0x0000004B; upper 24 bits unchanged.
- Rotate, long: Q = 0x80000001, size = long, sel = ROT, shift right → 0xC0000000.
- Force 1 and WBMSB: sel = ONE with shift left on Q = 0 → 0x00000001; then sel = WBMSB with wb_msb_h = 1 and shift right → 0x80000000.
- Multiply loop: start with N = 4, mul = 1, alu_sout_shr_h = 1, Q = 0 → loopf_h high for exactly 4 cycles, Q = 0xF0000000, loop_done_h pulses on cycle 5, then idle. A second start during RUN is ignored.
- Zero count and divide: start with N = 0 → done pulse next cycle, Q unchanged. Divide loop with N = 3 and c32_in_h = 1 from Q = 0 → Q = 0x00000007.
